ct_mmu_jtlb_tag_ctrl: RTL and testbench

CT_MMU_JTLB_TAG_CTRL -- requirements
Module: ct_mmu_jtlb_tag_ctrl

---
 rtl/ct_mmu_jtlb_pkg.sv | 55 +++++
 rtl/ct_mmu_jtlb_inv_sweep.sv | 61 ++++++
 rtl/ct_mmu_jtlb_tag_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ct_mmu_jtlb_tag_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_mmu_jtlb_pkg.sv
// Shared definitions for the JTLB tag-array controller: field widths,
// array layout offsets, FSM state encoding and victim/FIFO helper functions.
package ct_mmu_jtlb_pkg;

   localparam int TAG_W        = 48;
   localparam int WAY_N        = 4;
   localparam int IDX_W        = 8;
   localparam int VIC_W        = 2;
   localparam int FIFO_W       = WAY_N;
   localparam int WEN_W        = WAY_N + 1;
   localparam int TAGS_W       = TAG_W * WAY_N;
   localparam int DATA_W       = TAGS_W + FIFO_W;
   localparam int FIFO_LSB     = TAGS_W;
   localparam int WEN_FIFO_BIT = WAY_N;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RF_RD = 2'd1,
      ST_RF_WR = 2'd2,
      ST_INV   = 2'd3
   } jtlb_state_e;

   // Way number encoded by the one-hot FIFO pointer; a corrupted
   // (not one-hot) pointer falls back to way 0.
   function automatic logic [VIC_W-1:0] fifo_to_victim(input logic [FIFO_W-1:0] fifo);
      logic [VIC_W-1:0] v;
      case (fifo)
         4'b0001: v = 2'd0;
         4'b0010: v = 2'd1;
         4'b0100: v = 2'd2;
         4'b1000: v = 2'd3;
         default: v = 2'd0;
      endcase
      return v;
   endfunction

   // One-hot way mask for a way number.
   function automatic logic [FIFO_W-1:0] victim_onehot(input logic [VIC_W-1:0] v);
      logic [FIFO_W-1:0] oh;
      case (v)
         2'd0:    oh = 4'b0001;
         2'd1:    oh = 4'b0010;
         2'd2:    oh = 4'b0100;
         2'd3:    oh = 4'b1000;
         default: oh = 4'b0001;
      endcase
      return oh;
   endfunction

   // Advance the round-robin pointer by one way (rotate left by one).
   function automatic logic [FIFO_W-1:0] fifo_rotl1(input logic [FIFO_W-1:0] fifo);
      return {fifo[FIFO_W-2:0], fifo[FIFO_W-1]};
   endfunction

endpackage

// File: rtl/ct_mmu_jtlb_inv_sweep.sv
// Invalidate-all sweep engine: walks the index counter over every set,
// flags busy while sweeping and pulses done the cycle after the last set.
module ct_mmu_jtlb_inv_sweep
   import ct_mmu_jtlb_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_b_i,
   input  logic             start_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             last_o,
   output logic [IDX_W-1:0] cnt_o
);

   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [IDX_W-1:0] cnt_q,  cnt_d;
   logic             last_s;

   assign last_s = busy_q & (cnt_q == {IDX_W{1'b1}});

   // Next-state of the sweep: count while busy, stop and pulse done at the top index.
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      done_d = 1'b0;
      if (busy_q) begin
         if (last_s) begin
            busy_d = 1'b0;
            cnt_d  = {IDX_W{1'b0}};
            done_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + IDX_W'(1);
         end
      end else if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = {IDX_W{1'b0}};
      end else begin
         cnt_d  = {IDX_W{1'b0}};
      end
   end

   // Sweep state registers with synchronous active-low reset (aborts without done).
   always_ff @(posedge clk_i) begin
      if (!rst_b_i) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= {IDX_W{1'b0}};
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign last_o = last_s;
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/ct_mmu_jtlb_tag_ctrl.sv
// JTLB tag-array controller: arbitrates lookup reads, FIFO-victim refills
// (read-modify-write of the FIFO field) and full-array invalidation onto a
// single-port tag array with one-cycle read latency.
// Optional build macro CT_MMU_JTLB_TAG_DOUT_FLOP_EN registers the returned
// lookup tags/FIFO field, adding one cycle of lookup latency.
module ct_mmu_jtlb_tag_ctrl
   import ct_mmu_jtlb_pkg::*;
(
   input  logic               forever_cpuclk,
   input  logic               cpurst_b,
   input  logic               lookup_req,
   input  logic [IDX_W-1:0]   lookup_idx,
   output logic               lookup_gnt,
   output logic               lookup_vld,
   output logic [TAGS_W-1:0]  lookup_tags,
   output logic [FIFO_W-1:0]  lookup_fifo,
   input  logic               refill_req,
   input  logic [IDX_W-1:0]   refill_idx,
   input  logic [TAG_W-1:0]   refill_tag,
   output logic               refill_gnt,
   output logic               refill_done,
   output logic [VIC_W-1:0]   refill_victim,
   input  logic               inv_all_req,
   output logic               inv_busy,
   output logic               inv_done,
   output logic               jtlb_tag_cen,
   output logic [IDX_W-1:0]   jtlb_tag_idx,
   output logic [WEN_W-1:0]   jtlb_tag_wen,
   output logic [DATA_W-1:0]  jtlb_tag_din,
   input  logic [DATA_W-1:0]  jtlb_tag_dout
);

   jtlb_state_e       state_q, state_d;
   logic [IDX_W-1:0]  rf_idx_q, rf_idx_d;
   logic [TAG_W-1:0]  rf_tag_q, rf_tag_d;
   logic [VIC_W-1:0]  victim_q, victim_d;
   logic              inv_pend_q, inv_pend_d;
   logic              lk_vld_q;

   logic              sweep_start_s;
   logic              sweep_busy_s;
   logic              sweep_done_s;
   logic              sweep_last_s;
   logic [IDX_W-1:0]  sweep_cnt_s;
   logic [FIFO_W-1:0] victim_oh_s;

   logic              lookup_gnt_s;
   logic              refill_gnt_s;
   logic              refill_done_s;
   logic              cen_s;
   logic [IDX_W-1:0]  idx_s;
   logic [WEN_W-1:0]  wen_s;
   logic [DATA_W-1:0] din_s;

   ct_mmu_jtlb_inv_sweep u_inv_sweep (
      .clk_i   (forever_cpuclk),
      .rst_b_i (cpurst_b),
      .start_i (sweep_start_s),
      .busy_o  (sweep_busy_s),
      .done_o  (sweep_done_s),
      .last_o  (sweep_last_s),
      .cnt_o   (sweep_cnt_s)
   );

   assign victim_oh_s = victim_onehot(victim_q);

   // Arbitration, FSM next state and the single array access issued this cycle.
   always_comb begin
      state_d       = state_q;
      rf_idx_d      = rf_idx_q;
      rf_tag_d      = rf_tag_q;
      victim_d      = victim_q;
      inv_pend_d    = inv_pend_q;
      sweep_start_s = 1'b0;
      lookup_gnt_s  = 1'b0;
      refill_gnt_s  = 1'b0;
      refill_done_s = 1'b0;
      cen_s         = 1'b0;
      idx_s         = {IDX_W{1'b0}};
      wen_s         = {WEN_W{1'b0}};
      din_s         = {DATA_W{1'b0}};
      case (state_q)
         ST_IDLE: begin
            if (inv_all_req) begin
               sweep_start_s = 1'b1;
               state_d       = ST_INV;
            end else if (refill_req) begin
               refill_gnt_s  = 1'b1;
               rf_idx_d      = refill_idx;
               rf_tag_d      = refill_tag;
               cen_s         = 1'b1;
               idx_s         = refill_idx;
               state_d       = ST_RF_RD;
            end else if (lookup_req) begin
               lookup_gnt_s  = 1'b1;
               cen_s         = 1'b1;
               idx_s         = lookup_idx;
            end else begin
               state_d       = ST_IDLE;
            end
         end
         ST_RF_RD: begin
            // Victim always comes from the raw array output, never a flopped copy.
            victim_d = fifo_to_victim(jtlb_tag_dout[FIFO_LSB +: FIFO_W]);
            if (inv_all_req) begin
               inv_pend_d = 1'b1;
            end else begin
               inv_pend_d = inv_pend_q;
            end
            state_d = ST_RF_WR;
         end
         ST_RF_WR: begin
            cen_s         = 1'b1;
            idx_s         = rf_idx_q;
            wen_s         = {1'b1, victim_oh_s};
            din_s         = {fifo_rotl1(victim_oh_s), {WAY_N{rf_tag_q}}};
            refill_done_s = 1'b1;
            inv_pend_d    = 1'b0;
            // An invalidate held off during the refill starts right after it.
            if (inv_all_req || inv_pend_q) begin
               sweep_start_s = 1'b1;
               state_d       = ST_INV;
            end else begin
               state_d       = ST_IDLE;
            end
         end
         ST_INV: begin
            cen_s = 1'b1;
            idx_s = sweep_cnt_s;
            wen_s = {WEN_W{1'b1}};
            din_s = {DATA_W{1'b0}};
            if (sweep_last_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_INV;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Controller state and refill context with synchronous active-low reset.
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state_q    <= ST_IDLE;
         rf_idx_q   <= {IDX_W{1'b0}};
         rf_tag_q   <= {TAG_W{1'b0}};
         victim_q   <= {VIC_W{1'b0}};
         inv_pend_q <= 1'b0;
         lk_vld_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rf_idx_q   <= rf_idx_d;
         rf_tag_q   <= rf_tag_d;
         victim_q   <= victim_d;
         inv_pend_q <= inv_pend_d;
         lk_vld_q   <= lookup_gnt_s;
      end
   end

`ifdef CT_MMU_JTLB_TAG_DOUT_FLOP_EN
   logic              lk_vld2_q;
   logic [TAGS_W-1:0] lk_tags_q;
   logic [FIFO_W-1:0] lk_fifo_q;

   // Register returned lookup data the cycle it comes back from the array.
   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         lk_vld2_q <= 1'b0;
         lk_tags_q <= {TAGS_W{1'b0}};
         lk_fifo_q <= {FIFO_W{1'b0}};
      end else begin
         lk_vld2_q <= lk_vld_q;
         if (lk_vld_q) begin
            lk_tags_q <= jtlb_tag_dout[TAGS_W-1:0];
            lk_fifo_q <= jtlb_tag_dout[FIFO_LSB +: FIFO_W];
         end else begin
            lk_tags_q <= lk_tags_q;
            lk_fifo_q <= lk_fifo_q;
         end
      end
   end

   assign lookup_vld  = lk_vld2_q;
   assign lookup_tags = lk_tags_q;
   assign lookup_fifo = lk_fifo_q;
`else
   assign lookup_vld  = lk_vld_q;
   assign lookup_tags = jtlb_tag_dout[TAGS_W-1:0];
   assign lookup_fifo = jtlb_tag_dout[FIFO_LSB +: FIFO_W];
`endif

   assign lookup_gnt    = lookup_gnt_s;
   assign refill_gnt    = refill_gnt_s;
   assign refill_done   = refill_done_s;
   assign refill_victim = victim_q;
   assign inv_busy      = sweep_busy_s;
   assign inv_done      = sweep_done_s;
   assign jtlb_tag_cen  = cen_s;
   assign jtlb_tag_idx  = idx_s;
   assign jtlb_tag_wen  = wen_s;
   assign jtlb_tag_din  = din_s;

endmodule

// File: tb/tb_ct_mmu_jtlb_tag_ctrl.sv
// Directed table-driven bench for the JTLB tag-array controller (default build).
module tb_ct_mmu_jtlb_tag_ctrl;

   logic         clk;
   logic         cpurst_b;
   logic         lookup_req;
   logic [7:0]   lookup_idx;
   logic         lookup_gnt;
   logic         lookup_vld;
   logic [191:0] lookup_tags;
   logic [3:0]   lookup_fifo;
   logic         refill_req;
   logic [7:0]   refill_idx;
   logic [47:0]  refill_tag;
   logic         refill_gnt;
   logic         refill_done;
   logic [1:0]   refill_victim;
   logic         inv_all_req;
   logic         inv_busy;
   logic         inv_done;
   logic         jtlb_tag_cen;
   logic [7:0]   jtlb_tag_idx;
   logic [4:0]   jtlb_tag_wen;
   logic [195:0] jtlb_tag_din;
   logic [195:0] jtlb_tag_dout;

   int n_chk  = 0;
   int n_fail = 0;

   ct_mmu_jtlb_tag_ctrl dut (
      .forever_cpuclk (clk),
      .cpurst_b       (cpurst_b),
      .lookup_req     (lookup_req),
      .lookup_idx     (lookup_idx),
      .lookup_gnt     (lookup_gnt),
      .lookup_vld     (lookup_vld),
      .lookup_tags    (lookup_tags),
      .lookup_fifo    (lookup_fifo),
      .refill_req     (refill_req),
      .refill_idx     (refill_idx),
      .refill_tag     (refill_tag),
      .refill_gnt     (refill_gnt),
      .refill_done    (refill_done),
      .refill_victim  (refill_victim),
      .inv_all_req    (inv_all_req),
      .inv_busy       (inv_busy),
      .inv_done       (inv_done),
      .jtlb_tag_cen   (jtlb_tag_cen),
      .jtlb_tag_idx   (jtlb_tag_idx),
      .jtlb_tag_wen   (jtlb_tag_wen),
      .jtlb_tag_din   (jtlb_tag_din),
      .jtlb_tag_dout  (jtlb_tag_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic         rst_b;
      logic         lk_req;
      logic [7:0]   lk_idx;
      logic         rf_req;
      logic [7:0]   rf_idx;
      logic [47:0]  rf_tag;
      logic         inv_req;
      logic [195:0] dout;
      logic         e_lk_gnt;
      logic         e_lk_vld;
      logic         e_rf_gnt;
      logic         e_rf_done;
      logic [1:0]   e_vic;
      logic         e_cen;
      logic [4:0]   e_wen;
      logic [7:0]   e_idx;
      logic         e_busy;
      logic         e_inv_done;
      logic [195:0] e_din;
      logic [191:0] e_tags;
      logic [3:0]   e_fifo;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [195:0] act, input logic [195:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t blank();
      vec_t v;
      v = '{default: '0};
      v.rst_b = 1'b1;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int k);
      @(negedge clk);
      cpurst_b      = v.rst_b;
      lookup_req    = v.lk_req;
      lookup_idx    = v.lk_idx;
      refill_req    = v.rf_req;
      refill_idx    = v.rf_idx;
      refill_tag    = v.rf_tag;
      inv_all_req   = v.inv_req;
      jtlb_tag_dout = v.dout;
      #1;
      chk($sformatf("v%0d lookup_gnt", k),  196'(lookup_gnt),   196'(v.e_lk_gnt));
      chk($sformatf("v%0d lookup_vld", k),  196'(lookup_vld),   196'(v.e_lk_vld));
      chk($sformatf("v%0d refill_gnt", k),  196'(refill_gnt),   196'(v.e_rf_gnt));
      chk($sformatf("v%0d refill_done", k), 196'(refill_done),  196'(v.e_rf_done));
      chk($sformatf("v%0d cen", k),         196'(jtlb_tag_cen), 196'(v.e_cen));
      chk($sformatf("v%0d wen", k),         196'(jtlb_tag_wen), 196'(v.e_wen));
      chk($sformatf("v%0d inv_busy", k),    196'(inv_busy),     196'(v.e_busy));
      chk($sformatf("v%0d inv_done", k),    196'(inv_done),     196'(v.e_inv_done));
      if (v.e_cen)
         chk($sformatf("v%0d idx", k), 196'(jtlb_tag_idx), 196'(v.e_idx));
      if (v.e_rf_done)
         chk($sformatf("v%0d victim", k), 196'(refill_victim), 196'(v.e_vic));
      if (v.e_wen != 5'b00000)
         chk($sformatf("v%0d din", k), jtlb_tag_din, v.e_din);
      if (v.e_lk_vld) begin
         chk($sformatf("v%0d lookup_tags", k), 196'(lookup_tags), 196'(v.e_tags));
         chk($sformatf("v%0d lookup_fifo", k), 196'(lookup_fifo), 196'(v.e_fifo));
      end
   endtask

   initial begin
      vec_t         v;
      logic [195:0] dout_a;
      logic [195:0] dout_b;

      dout_a = {4'b0010, 48'h444444444444, 48'h333333333333, 48'h222222222222, 48'h111111111111};
      dout_b = {4'b1000, 48'hDDDDDDDDDDDD, 48'hCCCCCCCCCCCC, 48'hBBBBBBBBBBBB, 48'hAAAAAAAAAAAA};

      // 0: idle, nothing requested
      v = blank(); vecs.push_back(v);
      // 1-2: lookup idx 3A granted same cycle, data back next cycle
      v = blank(); v.lk_req = 1'b1; v.lk_idx = 8'h3A;
      v.e_lk_gnt = 1'b1; v.e_cen = 1'b1; v.e_idx = 8'h3A; vecs.push_back(v);
      v = blank(); v.dout = dout_a;
      v.e_lk_vld = 1'b1; v.e_tags = dout_a[191:0]; v.e_fifo = 4'b0010; vecs.push_back(v);
      // 3-5: refill beats lookup; fifo 0100 -> victim 2
      v = blank(); v.lk_req = 1'b1; v.lk_idx = 8'h77; v.rf_req = 1'b1; v.rf_idx = 8'h05; v.rf_tag = 48'hABC;
      v.e_rf_gnt = 1'b1; v.e_cen = 1'b1; v.e_idx = 8'h05; vecs.push_back(v);
      v = blank(); v.lk_req = 1'b1; v.lk_idx = 8'h77; v.dout = {4'b0100, 192'h0}; vecs.push_back(v);
      v = blank(); v.lk_req = 1'b1; v.lk_idx = 8'h77;
      v.e_rf_done = 1'b1; v.e_vic = 2'd2; v.e_cen = 1'b1; v.e_wen = 5'b10100; v.e_idx = 8'h05;
      v.e_din = {4'b1000, {4{48'h000000000ABC}}}; vecs.push_back(v);
      // 6-9: lookup, then refill with fifo 0000 -> victim 0
      v = blank(); v.lk_req = 1'b1; v.lk_idx = 8'h10;
      v.e_lk_gnt = 1'b1; v.e_cen = 1'b1; v.e_idx = 8'h10; vecs.push_back(v);
      v = blank(); v.dout = dout_b; v.rf_req = 1'b1; v.rf_idx = 8'hFF; v.rf_tag = 48'h123456789ABC;
      v.e_lk_vld = 1'b1; v.e_tags = dout_b[191:0]; v.e_fifo = 4'b1000;
      v.e_rf_gnt = 1'b1; v.e_cen = 1'b1; v.e_idx = 8'hFF; vecs.push_back(v);
      v = blank(); v.dout = {4'b0000, 192'h0}; vecs.push_back(v);
      v = blank();
      v.e_rf_done = 1'b1; v.e_vic = 2'd0; v.e_cen = 1'b1; v.e_wen = 5'b10001; v.e_idx = 8'hFF;
      v.e_din = {4'b0010, {4{48'h123456789ABC}}}; vecs.push_back(v);
      // 10-12: fifo 1000 -> victim 3, pointer wraps to 0001
      v = blank(); v.rf_req = 1'b1; v.rf_idx = 8'h80; v.rf_tag = 48'hFFFF0000FFFF;
      v.e_rf_gnt = 1'b1; v.e_cen = 1'b1; v.e_idx = 8'h80; vecs.push_back(v);
      v = blank(); v.dout = {4'b1000, 192'h0}; vecs.push_back(v);
      v = blank();
      v.e_rf_done = 1'b1; v.e_vic = 2'd3; v.e_cen = 1'b1; v.e_wen = 5'b11000; v.e_idx = 8'h80;
      v.e_din = {4'b0001, {4{48'hFFFF0000FFFF}}}; vecs.push_back(v);
      // 13-15: non-one-hot fifo 0110 -> victim 0
      v = blank(); v.rf_req = 1'b1; v.rf_idx = 8'h01; v.rf_tag = 48'h000000000001;
      v.e_rf_gnt = 1'b1; v.e_cen = 1'b1; v.e_idx = 8'h01; vecs.push_back(v);
      v = blank(); v.dout = {4'b0110, 192'h0}; vecs.push_back(v);
      v = blank();
      v.e_rf_done = 1'b1; v.e_vic = 2'd0; v.e_cen = 1'b1; v.e_wen = 5'b10001; v.e_idx = 8'h01;
      v.e_din = {4'b0010, {4{48'h000000000001}}}; vecs.push_back(v);
      // 16-20: inv pulse during RF_RD held off; refill finishes, sweep starts after
      v = blank(); v.rf_req = 1'b1; v.rf_idx = 8'h22; v.rf_tag = 48'h00000000DEAD;
      v.e_rf_gnt = 1'b1; v.e_cen = 1'b1; v.e_idx = 8'h22; vecs.push_back(v);
      v = blank(); v.dout = {4'b0001, 192'h0}; v.inv_req = 1'b1; v.lk_req = 1'b1; vecs.push_back(v);
      v = blank();
      v.e_rf_done = 1'b1; v.e_vic = 2'd0; v.e_cen = 1'b1; v.e_wen = 5'b10001; v.e_idx = 8'h22;
      v.e_din = {4'b0010, {4{48'h00000000DEAD}}}; vecs.push_back(v);
      v = blank(); v.lk_req = 1'b1; v.rf_req = 1'b1;
      v.e_busy = 1'b1; v.e_cen = 1'b1; v.e_wen = 5'b11111; v.e_idx = 8'h00; vecs.push_back(v);
      v = blank();
      v.e_busy = 1'b1; v.e_cen = 1'b1; v.e_wen = 5'b11111; v.e_idx = 8'h01; vecs.push_back(v);
      // 21-22: reset during sweep aborts it without a done pulse
      v = blank(); v.rst_b = 1'b0;
      v.e_busy = 1'b1; v.e_cen = 1'b1; v.e_wen = 5'b11111; v.e_idx = 8'h02; vecs.push_back(v);
      v = blank(); vecs.push_back(v);

      // Reset with all requests idle, then check reset state
      cpurst_b = 1'b0; lookup_req = 1'b0; lookup_idx = 8'h00; refill_req = 1'b0;
      refill_idx = 8'h00; refill_tag = 48'h0; inv_all_req = 1'b0; jtlb_tag_dout = 196'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst lookup_vld",  196'(lookup_vld),   196'(1'b0));
      chk("rst refill_done", 196'(refill_done),  196'(1'b0));
      chk("rst inv_done",    196'(inv_done),     196'(1'b0));
      chk("rst inv_busy",    196'(inv_busy),     196'(1'b0));
      chk("rst cen",         196'(jtlb_tag_cen), 196'(1'b0));
      chk("rst wen",         196'(jtlb_tag_wen), 196'(5'b00000));

      foreach (vecs[k]) run_vec(vecs[k], k);

      // Invalidate, refill and lookup together: full 256-entry sweep first
      @(negedge clk);
      inv_all_req = 1'b1; refill_req = 1'b1; refill_idx = 8'h44; refill_tag = 48'h55;
      lookup_req = 1'b1; lookup_idx = 8'h66;
      #1;
      chk("swp start lookup_gnt", 196'(lookup_gnt),   196'(1'b0));
      chk("swp start refill_gnt", 196'(refill_gnt),   196'(1'b0));
      chk("swp start cen",        196'(jtlb_tag_cen), 196'(1'b0));
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("swp%0d busy", i), 196'(inv_busy), 196'(1'b1));
         chk($sformatf("swp%0d cen", i),  196'(jtlb_tag_cen), 196'(1'b1));
         chk($sformatf("swp%0d wen", i),  196'(jtlb_tag_wen), 196'(5'b11111));
         chk($sformatf("swp%0d idx", i),  196'(jtlb_tag_idx), 196'(i));
         chk($sformatf("swp%0d din", i),  jtlb_tag_din, 196'h0);
         chk($sformatf("swp%0d gnt", i),  196'({lookup_gnt, refill_gnt}), 196'(2'b00));
         chk($sformatf("swp%0d inv_done", i), 196'(inv_done), 196'(1'b0));
      end
      @(negedge clk);
      inv_all_req = 1'b0;
      #1;
      chk("swp end inv_done",   196'(inv_done),     196'(1'b1));
      chk("swp end inv_busy",   196'(inv_busy),     196'(1'b0));
      chk("swp end refill_gnt", 196'(refill_gnt),   196'(1'b1));
      chk("swp end lookup_gnt", 196'(lookup_gnt),   196'(1'b0));
      chk("swp end idx",        196'(jtlb_tag_idx), 196'(8'h44));
      @(negedge clk);
      refill_req = 1'b0; lookup_req = 1'b0; jtlb_tag_dout = {4'b0001, 192'h0};
      #1;
      chk("post swp inv_done", 196'(inv_done),     196'(1'b0));
      chk("post swp rd cen",   196'(jtlb_tag_cen), 196'(1'b0));
      @(negedge clk);
      #1;
      chk("post swp refill_done", 196'(refill_done),  196'(1'b1));
      chk("post swp wen",         196'(jtlb_tag_wen), 196'(5'b10001));
      chk("post swp din",         jtlb_tag_din, {4'b0010, {4{48'h000000000055}}});

      // Reset at sweep index 100: no done pulse, next sweep restarts at 0
      @(negedge clk);
      inv_all_req = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         @(negedge clk);
         inv_all_req = 1'b0;
         #1;
         if (i == 100) begin
            chk("abort idx", 196'(jtlb_tag_idx), 196'(8'd100));
            cpurst_b = 1'b0;
         end
      end
      @(negedge clk);
      cpurst_b = 1'b1;
      #1;
      chk("abort inv_busy", 196'(inv_busy),     196'(1'b0));
      chk("abort inv_done", 196'(inv_done),     196'(1'b0));
      chk("abort cen",      196'(jtlb_tag_cen), 196'(1'b0));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("abort quiet%0d inv_done", i), 196'(inv_done), 196'(1'b0));
      end
      @(negedge clk);
      inv_all_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         inv_all_req = 1'b0;
         #1;
         chk($sformatf("restart%0d busy", i), 196'(inv_busy),     196'(1'b1));
         chk($sformatf("restart%0d idx", i),  196'(jtlb_tag_idx), 196'(i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
